// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types and constants for the data-memory responder
// State encoding, legal store byte-enable patterns and the store log format.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  localparam string LOG_FMT = "@%h: *%h <= %h";

endpackage

// File: rtl/dm_be_merge.sv
// rtl/dm_be_merge.sv - byte-enable merge of store data into the old word
// Also flags whether the enable pattern is an aligned byte, halfword or word.
module dm_be_merge
  import dm_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] merged,
  output logic        be_legal
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: be_legal = 1'b1;
      default:                                        be_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - fixed-latency data-memory responder with valid/ready request and response
// One request in flight; access happens LATENCY cycles after acceptance.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  state_t                state;
  logic [3:0]            cnt;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] word_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic [31:0]           pc_q;
  logic                  range_err_q;
  logic [31:0]           mem [2**ADDR_WIDTH];

  logic [31:0] merged;
  logic        be_legal;
  logic        access_err;
  logic [31:0] byte_addr;

  // Byte-offset bits carry no meaning for a word-addressed memory.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^req_addr[1:0];

  dm_be_merge u_merge (
    .old_word (mem[word_q]),
    .wdata    (wdata_q),
    .be       (be_q),
    .merged   (merged),
    .be_legal (be_legal)
  );

  assign access_err = range_err_q | (write_q & ~be_legal);
  assign byte_addr  = {{(30-ADDR_WIDTH){1'b0}}, word_q, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            word_q      <= req_addr[ADDR_WIDTH+1:2];
            be_q        <= req_be;
            wdata_q     <= req_wdata;
            pc_q        <= req_pc;
            range_err_q <= |req_addr[31:ADDR_WIDTH+2];
            cnt         <= 4'(LATENCY - 1);
            req_ready   <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            resp_err   <= access_err;
            resp_rdata <= (access_err || write_q) ? 32'd0 : mem[word_q];
            if (write_q && !access_err) begin
              mem[word_q] <= merged;
              $display(LOG_FMT, pc_q, byte_addr, merged);
            end
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the multi-cycle and pipelined CPU variants: the memory-side end of the CPU's load/store interface. It accepts one word-addressed request at a time over a valid/ready handshake, waits a configurable access latency, performs a byte-enabled write or a full-word read, and returns a response over a second valid/ready handshake. It replaces the zero-latency data memory when the core must tolerate memory stalls.

## Interface
- ADDR_WIDTH, 10, word-address bits; capacity 2^ADDR_WIDTH words.
- LATENCY, 2, cycles from acceptance to access; legal range 1..15.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_be  in  4  byte enables for stores; bit i covers bits [8i+7:8i].
- req_wdata  in  32  store data, already lane-aligned.
- req_pc  in  32  PC of the issuing instruction, used for the write log.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  loaded word; 0 for stores and errors.
- resp_err  out  1  request rejected: out of range or illegal byte enable.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1, resp_valid=0. On req_valid, latch write, word address, be, wdata, pc; load cnt=LATENCY-1; go to WAIT.
- WAIT: req_ready=0. If cnt==0, perform the access and go to RESP; else decrement cnt.
- Access: err=1 if req_addr[31:ADDR_WIDTH+2]!=0, or if a store's be is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111. Loads ignore be.
- Store without error: mem[word] = merge(old, wdata, be). Log with $display "@%h: *%h <= %h": pc, word-aligned byte address, merged word.
- Load without error: rdata = mem[word].
- On err, memory is unchanged, there is no log line, and rdata=0.
- RESP: resp_valid=1; rdata and err are stable. On resp_ready, go to IDLE. The response is held indefinitely while resp_ready=0.
- Reset, including mid-transaction: state=IDLE, cnt=0, all memory words=0, resp_rdata=0, resp_err=0, resp_valid=0, req_ready=1 in the cycle after reset deasserts. An in-flight request is dropped with no write.

## Timing
- Acceptance happens at edge N when req_valid & req_ready.
- Access happens at edge N+LATENCY. resp_valid is high from that edge.
- Response completes at the first edge with resp_valid & resp_ready. req_ready rises after that edge. Accept and respond never coincide.
- Minimum request spacing is LATENCY+2 cycles.
- The response registers (rdata, err) change only at the access edge and at reset.
- Request inputs are sampled only at acceptance. Later changes are ignored.

## Structure
- Package dm_pkg holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the legal byte-enable constants;
  - the log format string.
- Sub-module dm_be_merge: combinational; takes old word, wdata and be; outputs the merged word and a be_legal flag.
- The memory array, counter and FSM stay in dm_responder.

## Test plan
- Reset, then store 0x12345678 to 0x00000004 with be=1111 and pc=0x00003000. Then load 0x00000004. Required: resp_rdata=0x12345678, err=0, log line "@00003000: *00000004 <= 12345678", resp_valid 2 cycles after each acceptance.
- Store 0x0000AB00 with be=0010 over 0x12345678, then load. Required: 0x1234AB78. Repeat with be=1100 and wdata 0xCDEF0000. Required: 0xCDEFAB78.
- Store with be=0101, and store to address 0x00001000 (ADDR_WIDTH=10). Required: err=1, rdata=0, no log line, memory unchanged on re-read.
- Hold resp_ready=0 for 5 cycles after resp_valid. Required: resp_valid, rdata and err stable; req_ready=0; a new req_valid is not accepted until after the completing edge.
- Assert reset during WAIT of a store to 0x8. Required: no log line; the next load of 0x8 returns 0; req_ready=1 in the first cycle after reset.
- LATENCY=1 with back-to-back requests. Required: acceptances spaced exactly 3 cycles apart with resp_ready tied high.
